// File: rtl/spi_slave_responder.sv
// rtl/spi_slave_responder.sv - SPI mode-0 slave with TX holding register and RX frame FIFO
module spi_slave_responder #(
    parameter int                DATA_W   = 32,
    parameter int                RX_DEPTH = 4,
    parameter logic [DATA_W-1:0] TX_IDLE  = 32'h0000_0000
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              SCLK,
    input  logic              SS_N,
    input  logic              MOSI,
    output logic              MISO,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              rx_overflow,
    output logic              tx_underrun,
    output logic              frame_abort
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam int PTR_W = $clog2(RX_DEPTH);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(RX_DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
    state_t state, state_d;

    logic sclk_s1, sclk_s2, sclk_d;
    logic ss_s1, ss_s2, ss_d;
    logic mosi_s1, mosi_s2;
    logic sclk_rise, sclk_fall, ss_fall, ss_rise;

    logic [CNT_W-1:0]  bit_cnt;
    logic              reload_pend;
    logic [DATA_W-2:0] rx_shift;
    logic [DATA_W-1:0] rx_word;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] hold_data;
    logic              hold_full;
    logic              load_tx, shift_rx, shift_tx, abort_ev;
    logic              word_done, pop, push_ok, tx_accept;

    logic [DATA_W-1:0] fifo_mem [RX_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    fifo_cnt;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            {sclk_s1, sclk_s2, sclk_d} <= 3'b000;
            {ss_s1, ss_s2, ss_d}       <= 3'b111;
            {mosi_s1, mosi_s2}         <= 2'b00;
        end else begin
            {sclk_s1, sclk_s2, sclk_d} <= {SCLK, sclk_s1, sclk_s2};
            {ss_s1, ss_s2, ss_d}       <= {SS_N, ss_s1, ss_s2};
            {mosi_s1, mosi_s2}         <= {MOSI, mosi_s1};
        end
    end

    assign sclk_rise = sclk_s2 & ~sclk_d;
    assign sclk_fall = ~sclk_s2 & sclk_d;
    assign ss_fall   = ~ss_s2 & ss_d;
    assign ss_rise   = ss_s2 & ~ss_d;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) state <= IDLE;
        else          state <= state_d;
    end

    // SS_N rising is checked before any SCLK edge so a coincident final fall never reloads.
    always_comb begin
        state_d  = state;
        load_tx  = 1'b0;
        shift_rx = 1'b0;
        shift_tx = 1'b0;
        abort_ev = 1'b0;
        case (state)
            IDLE: if (ss_fall) state_d = LOAD;
            LOAD: begin
                load_tx = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (ss_rise) begin
                    state_d  = IDLE;
                    abort_ev = (bit_cnt != '0);
                end else if (sclk_rise) begin
                    shift_rx = 1'b1;
                end else if (sclk_fall) begin
                    load_tx  = reload_pend;
                    shift_tx = !reload_pend;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_word   = {rx_shift, mosi_s2};
    assign word_done = shift_rx && (bit_cnt == LAST_BIT);
    assign pop       = rx_valid && rx_ready;
    assign push_ok   = word_done && ((fifo_cnt != FIFO_FULL) || pop);
    assign tx_ready  = !hold_full && (state != LOAD);
    assign tx_accept = tx_valid && tx_ready;
    assign MISO      = (state == SHIFT) ? tx_shift[DATA_W-1] : 1'b0;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            bit_cnt     <= '0;
            reload_pend <= 1'b0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            hold_data   <= '0;
            hold_full   <= 1'b0;
            rx_overflow <= 1'b0;
            tx_underrun <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            rx_overflow <= word_done && !push_ok;
            frame_abort <= abort_ev;
            tx_underrun <= 1'b0;
            if (shift_rx) begin
                rx_shift <= rx_word[DATA_W-2:0];
                if (word_done) begin
                    bit_cnt     <= '0;
                    reload_pend <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else if (state != SHIFT) begin
                bit_cnt     <= '0;
                reload_pend <= 1'b0;
            end
            if (load_tx) begin
                reload_pend <= 1'b0;
                tx_shift    <= hold_full ? hold_data : TX_IDLE;
                tx_underrun <= !hold_full;
            end else if (shift_tx) begin
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            end
            if (load_tx && hold_full) begin
                hold_full <= 1'b0;
            end else if (tx_accept) begin
                hold_full <= 1'b1;
                hold_data <= tx_data;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (push_ok) fifo_mem[wr_ptr] <= rx_word;
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign rx_valid = (fifo_cnt != '0);
    assign rx_data  = rx_valid ? fifo_mem[rd_ptr] : '0;
endmodule

// File: tb/tb_spi_slave_responder.sv
// tb/tb_spi_slave_responder.sv - directed self-checking bench for spi_slave_responder
module tb_spi_slave_responder;
    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        SCLK = 1'b0;
    logic        SS_N = 1'b1;
    logic        MOSI = 1'b0;
    logic        MISO;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic [31:0] tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic        rx_overflow, tx_underrun, frame_abort;

    int checks = 0;
    int errors = 0;
    int ovf_cnt = 0, und_cnt = 0, abt_cnt = 0;

    spi_slave_responder dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .SCLK(SCLK), .SS_N(SS_N), .MOSI(MOSI), .MISO(MISO),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_overflow(rx_overflow), .tx_underrun(tx_underrun), .frame_abort(frame_abort)
    );

    always #5 ACLK = ~ACLK;

    always @(negedge ACLK) begin
        if (rx_overflow) ovf_cnt++;
        if (tx_underrun) und_cnt++;
        if (frame_abort) abt_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic ss_start();
        SS_N = 1'b0;
        repeat (8) @(negedge ACLK);
    endtask

    // SCLK half period is four ACLK cycles; the last fall coincides with SS_N rise when end_ss is set.
    task automatic spi_xfer(input logic [31:0] m_word, input int nbits, input bit end_ss,
                            input bit pop_last, output logic [31:0] s_word);
        s_word = '0;
        for (int i = 0; i < nbits; i++) begin
            MOSI = m_word[31-i];
            repeat (4) @(negedge ACLK);
            SCLK   = 1'b1;
            s_word = {s_word[30:0], MISO};
            if (pop_last && i == nbits - 1) begin
                repeat (2) @(negedge ACLK);
                rx_ready = 1'b1;
                @(negedge ACLK);
                rx_ready = 1'b0;
                @(negedge ACLK);
            end else begin
                repeat (4) @(negedge ACLK);
            end
            SCLK = 1'b0;
            if (end_ss && i == nbits - 1) SS_N = 1'b1;
        end
        if (end_ss) repeat (8) @(negedge ACLK);
    endtask

    task automatic tx_load(input logic [31:0] d);
        check("tx_ready_before_load", tx_ready, 1'b1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge ACLK);
        tx_valid = 1'b0;
        check("tx_ready_after_load", tx_ready, 1'b0);
    endtask

    task automatic pop_check(input string tag, input logic [31:0] exp);
        check(tag, rx_data, exp);
        rx_ready = 1'b1;
        @(negedge ACLK);
        rx_ready = 1'b0;
    endtask

    logic [31:0] s0, s1;
    int base_o, base_u, base_a;

    initial begin
        repeat (3) @(negedge ACLK);
        check("rst_miso", MISO, 1'b0);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_rx_data", rx_data, 32'h0);
        check("rst_tx_ready", tx_ready, 1'b1);
        check("rst_pulses", {rx_overflow, tx_underrun, frame_abort}, 3'b000);
        ARESETN = 1'b1;
        repeat (4) @(negedge ACLK);

        // single frame with a loaded response word
        base_u = und_cnt;
        tx_load(32'hA5A5_0F0F);
        ss_start();
        spi_xfer(32'h1234_5678, 32, 1'b1, 1'b0, s0);
        check("f1_miso", s0, 32'hA5A5_0F0F);
        check("f1_rx_valid", rx_valid, 1'b1);
        check("f1_tx_ready", tx_ready, 1'b1);
        check("f1_underrun", und_cnt - base_u, 0);
        pop_check("f1_rx_data", 32'h1234_5678);
        check("f1_empty", rx_valid, 1'b0);

        // back-to-back frames, one tx word
        base_u = und_cnt;
        tx_load(32'h1122_3344);
        ss_start();
        spi_xfer(32'hAAAA_0001, 32, 1'b0, 1'b0, s0);
        spi_xfer(32'hBBBB_0002, 32, 1'b1, 1'b0, s1);
        check("b2b_miso1", s0, 32'h1122_3344);
        check("b2b_miso2", s1, 32'h0000_0000);
        check("b2b_underrun", und_cnt - base_u, 1);
        pop_check("b2b_rx0", 32'hAAAA_0001);
        pop_check("b2b_rx1", 32'hBBBB_0002);
        check("b2b_empty", rx_valid, 1'b0);

        // overflow on the fifth frame
        base_o = ovf_cnt;
        for (int k = 0; k < 5; k++) begin
            ss_start();
            spi_xfer(32'hC0DE_0000 + k, 32, 1'b1, 1'b0, s0);
        end
        check("ovf_pulse", ovf_cnt - base_o, 1);
        for (int k = 0; k < 4; k++) pop_check($sformatf("ovf_rx%0d", k), 32'hC0DE_0000 + k);
        check("ovf_empty", rx_valid, 1'b0);

        // full FIFO with a pop on the final edge accepts the frame
        base_o = ovf_cnt;
        for (int k = 0; k < 4; k++) begin
            ss_start();
            spi_xfer(32'hD00D_0000 + k, 32, 1'b1, 1'b0, s0);
        end
        ss_start();
        spi_xfer(32'hD00D_0004, 32, 1'b1, 1'b1, s0);
        check("full_pop_no_ovf", ovf_cnt - base_o, 0);
        for (int k = 1; k < 5; k++) pop_check($sformatf("full_pop_rx%0d", k), 32'hD00D_0000 + k);
        check("full_pop_empty", rx_valid, 1'b0);

        // abort after 13 bits
        base_a = abt_cnt;
        ss_start();
        spi_xfer(32'hFFFF_FFFF, 13, 1'b1, 1'b0, s0);
        check("abort_pulse", abt_cnt - base_a, 1);
        check("abort_fifo", rx_valid, 1'b0);
        ss_start();
        spi_xfer(32'h0F0F_1234, 32, 1'b1, 1'b0, s0);
        check("abort_no_more", abt_cnt - base_a, 1);
        pop_check("abort_next_rx", 32'h0F0F_1234);

        // reset mid-frame at bit 20
        base_a = abt_cnt;
        tx_load(32'h5555_AAAA);
        ss_start();
        spi_xfer(32'h8765_4321, 20, 1'b0, 1'b0, s0);
        ARESETN = 1'b0;
        @(negedge ACLK);
        ARESETN = 1'b1;
        check("mrst_miso", MISO, 1'b0);
        check("mrst_rx_valid", rx_valid, 1'b0);
        check("mrst_rx_data", rx_data, 32'h0);
        check("mrst_tx_ready", tx_ready, 1'b1);
        check("mrst_pulses", {rx_overflow, tx_underrun, frame_abort}, 3'b000);
        SS_N = 1'b1;
        repeat (8) @(negedge ACLK);
        tx_load(32'h3C3C_C3C3);
        ss_start();
        spi_xfer(32'h2468_ACE0, 32, 1'b1, 1'b0, s0);
        check("mrst_no_abort", abt_cnt - base_a, 0);
        check("mrst_next_miso", s0, 32'h3C3C_C3C3);
        pop_check("mrst_next_rx", 32'h2468_ACE0);

        // simultaneous push and pop at count 2
        for (int k = 0; k < 2; k++) begin
            ss_start();
            spi_xfer(32'hE000_0000 + k, 32, 1'b1, 1'b0, s0);
        end
        ss_start();
        spi_xfer(32'hE000_0002, 32, 1'b1, 1'b1, s0);
        pop_check("pp_rx1", 32'hE000_0001);
        pop_check("pp_rx2", 32'hE000_0002);
        check("pp_empty", rx_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
